// File: rtl/mmio_pkg.sv
// Address map and STATUS layout shared by the data-memory responder and the bench.
package mmio_pkg;

  localparam logic [31:0] MMIO_CYCLE   = 32'hFFFF_FF00;
  localparam logic [31:0] MMIO_CONDATA = 32'hFFFF_FF04;
  localparam logic [31:0] MMIO_STATUS  = 32'hFFFF_FF08;

  localparam int ST_OCC_LSB   = 0;
  localparam int ST_FULL_BIT  = 8;
  localparam int ST_EMPTY_BIT = 9;
  localparam int ST_DROP_LSB  = 16;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CYCLE,
    SEL_CONDATA,
    SEL_STATUS
  } dmem_sel_e;

  // Byte lanes [1:0] play no part in decoding.
  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-facing data-memory bus plus the console drain handshake.
interface data_mem_responder_if;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  modport master (
    output MemWrite, Addr, WriteData, con_ready,
    input  ReadData, con_valid, con_data
  );

  modport slave (
    input  MemWrite, Addr, WriteData, con_ready,
    output ReadData, con_valid, con_data
  );
endinterface

// File: rtl/data_mem_responder_console_fifo.sv
// Byte FIFO for the console; head byte reads as 0 whenever the FIFO is empty.
module console_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [7:0]                    data_i,
  input  logic                          pop_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic [7:0]                    head_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only taken if the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_q] <= data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_q];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM, console FIFO and MMIO status/cycle registers.
// Build option DMEM_CYCLE_COUNTER_EN adds the free-running cycle counter at CYCLE.
module data_mem_responder
  import mmio_pkg::*;
#(
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

  dmem_sel_e      sel;
  logic [AW-1:0]  ram_idx;
  logic [31:0]    ram_q [MEM_WORDS];
  logic [31:0]    rdata, status, cyc_val;
  logic [7:0]     drop_q, drop_d;
  logic           push, pop, fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_cnt;

  always_comb begin
    sel = SEL_NONE;
    if (bus.Addr < RAM_BYTES)                sel = SEL_RAM;
    else if (word_match(bus.Addr, MMIO_CYCLE))   sel = SEL_CYCLE;
    else if (word_match(bus.Addr, MMIO_CONDATA)) sel = SEL_CONDATA;
    else if (word_match(bus.Addr, MMIO_STATUS))  sel = SEL_STATUS;
  end

  assign ram_idx = bus.Addr[AW+1:2];

  // RAM holds its contents through reset; same-cycle reads see the old word.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && sel == SEL_RAM) ram_q[ram_idx] <= bus.WriteData;
  end

  assign push = bus.MemWrite && (sel == SEL_CONDATA);
  assign pop  = bus.con_valid && bus.con_ready;

  console_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_console_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (bus.WriteData[7:0]),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt),
    .head_o  (bus.con_data)
  );

  assign bus.con_valid = !fifo_empty;

  always_comb begin
    drop_d = drop_q;
    if (push && fifo_full && !pop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_q + 32'd1;
  end

  assign cyc_val = cyc_q;
`else
  assign cyc_val = '0;
`endif

  always_comb begin
    status                       = '0;
    status[ST_OCC_LSB +: 8]      = 8'(fifo_cnt);
    status[ST_FULL_BIT]          = fifo_full;
    status[ST_EMPTY_BIT]         = fifo_empty;
    status[ST_DROP_LSB +: 8]     = drop_q;
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_RAM:    rdata = ram_q[ram_idx];
      SEL_CYCLE:  rdata = cyc_val;
      SEL_STATUS: rdata = status;
      default:    rdata = '0;
    endcase
  end

  assign bus.ReadData = rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder; CYCLE expectations follow DMEM_CYCLE_COUNTER_EN.
module tb_data_mem_responder;
  import mmio_pkg::*;

`ifdef DMEM_CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  localparam logic [31:0] UNMAP = 32'h8000_0000;

  // Probe kinds: 1 = ReadData, 2 = con_valid, 3 = con_data
  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } chk_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(
    .MEM_WORDS (64),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  chk_t        chk_q[$];
  logic [7:0]  byte_q[$];
  int          probe_kind = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  chk_t        mon_c;
  logic [31:0] mon_act;
  logic [7:0]  mon_b;

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic rdy, input int kind, input logic [31:0] exp,
                       input string nm);
    chk_t c;
    bus.MemWrite  = we;
    bus.Addr      = a;
    bus.WriteData = wd;
    bus.con_ready = rdy;
    probe_kind    = kind;
    if (kind != 0) begin
      c.kind = kind;
      c.val  = exp;
      c.name = nm;
      chk_q.push_back(c);
    end
    @(posedge clk);
    #1;
    probe_kind = 0;
    cyc++;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, UNMAP, 32'h0, rdy, 0, 32'h0, "");
  endtask

  always @(negedge clk) begin
    if (probe_kind != 0) begin
      n_cmp++;
      if (chk_q.size() == 0) begin
        n_bad++;
        $display("FAIL probe: no expected value queued");
      end else begin
        mon_c = chk_q.pop_front();
        case (mon_c.kind)
          1:       mon_act = bus.ReadData;
          2:       mon_act = {31'b0, bus.con_valid};
          default: mon_act = {24'b0, bus.con_data};
        endcase
        if (mon_act !== mon_c.val) begin
          n_bad++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", mon_c.name, mon_act, mon_c.val);
        end
      end
    end
    if (bus.con_valid === 1'b1 && bus.con_ready === 1'b1) begin
      n_cmp++;
      if (byte_q.size() == 0) begin
        n_bad++;
        $display("FAIL con_drain: got byte 0x%02h expected no byte", bus.con_data);
      end else begin
        mon_b = byte_q.pop_front();
        if (bus.con_data !== mon_b) begin
          n_bad++;
          $display("FAIL con_drain: got 0x%02h expected 0x%02h", bus.con_data, mon_b);
        end
      end
    end
  end

  initial begin
    bus.MemWrite  = 1'b0;
    bus.Addr      = UNMAP;
    bus.WriteData = 32'h0;
    bus.con_ready = 1'b0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Reset state
    drive(1'b0, MMIO_CYCLE,  32'h0, 1'b0, 1, 32'h0, "cycle_after_reset");
    drive(1'b0, MMIO_CYCLE,  32'h0, 1'b0, 1, CYC_EN ? 32'd1 : 32'd0, "cycle_count_1");
    drive(1'b0, MMIO_STATUS, 32'h0, 1'b0, 1, 32'h0000_0200, "status_reset");
    drive(1'b0, UNMAP,       32'h0, 1'b0, 2, 32'h0, "con_valid_reset");
    drive(1'b0, UNMAP,       32'h0, 1'b0, 3, 32'h0, "con_data_reset");

    // RAM store/load and decode edges
    drive(1'b1, 32'h10, 32'h1111_1111, 1'b0, 0, 32'h0, "");
    drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1, 32'h1111_1111, "ram_same_cycle_old");
    drive(1'b0, 32'h10, 32'h0,         1'b0, 1, 32'hDEAD_BEEF, "ram_readback");
    drive(1'b1, 32'h00, 32'hA5A5_A5A5, 1'b0, 0, 32'h0, "");
    drive(1'b1, 32'h100, 32'h1234_5678, 1'b0, 1, 32'h0, "ram_limit_read_during_write");
    drive(1'b0, 32'h100, 32'h0,        1'b0, 1, 32'h0, "ram_limit_unmapped");
    drive(1'b0, 32'h00,  32'h0,        1'b0, 1, 32'hA5A5_A5A5, "ram_no_alias");
    drive(1'b1, 32'hFC,  32'hCAFE_F00D, 1'b0, 0, 32'h0, "");
    drive(1'b0, 32'hFE,  32'h0,        1'b0, 1, 32'hCAFE_F00D, "ram_top_word_low_bits");
    drive(1'b1, MMIO_STATUS, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, "");
    drive(1'b0, MMIO_STATUS, 32'h0,    1'b0, 1, 32'h0000_0200, "status_write_ignored");

    // Console drain
    byte_q.push_back(8'h41);
    drive(1'b1, MMIO_CONDATA, 32'h0000_0041, 1'b1, 1, 32'h0, "condata_reads_zero");
    byte_q.push_back(8'h42);
    drive(1'b1, MMIO_CONDATA, 32'h0000_0042, 1'b1, 2, 32'h1, "con_valid_after_push");
    idle(1'b1);
    drive(1'b0, MMIO_STATUS, 32'h0, 1'b1, 1, 32'h0000_0200, "status_after_drain");

    // Overflow: last two bytes dropped
    for (int i = 0; i < 6; i++) begin
      if (i < 4) byte_q.push_back(8'(8'h61 + i));
      drive(1'b1, MMIO_CONDATA, 32'(8'h61 + i), 1'b0, 0, 32'h0, "");
    end
    drive(1'b0, MMIO_STATUS, 32'h0, 1'b0, 1, 32'h0002_0104, "status_overflow");

    // Full with simultaneous push and pop
    byte_q.push_back(8'h5A);
    drive(1'b1, MMIO_CONDATA, 32'h0000_005A, 1'b1, 0, 32'h0, "");
    drive(1'b0, MMIO_STATUS, 32'h0, 1'b0, 1, 32'h0002_0104, "status_full_push_pop");
    repeat (5) idle(1'b1);
    drive(1'b0, MMIO_STATUS, 32'h0, 1'b1, 1, 32'h0002_0200, "status_drained_drops_kept");

    // Reset mid-operation
    while (cyc < 100) idle(1'b0);
    drive(1'b0, MMIO_CYCLE, 32'h0, 1'b0, 1, CYC_EN ? 32'd100 : 32'd0, "cycle_at_100");
    for (int i = 0; i < 3; i++)
      drive(1'b1, MMIO_CONDATA, 32'(8'h70 + i), 1'b0, 0, 32'h0, "");
    reset         = 1'b1;
    bus.MemWrite  = 1'b1;
    bus.Addr      = MMIO_CONDATA;
    bus.WriteData = 32'h0000_0077;
    bus.con_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    drive(1'b0, MMIO_CYCLE,  32'h0, 1'b0, 1, 32'h0, "cycle_first_after_midreset");
    drive(1'b0, MMIO_STATUS, 32'h0, 1'b1, 1, 32'h0000_0200, "status_after_midreset");
    drive(1'b0, UNMAP, 32'h0, 1'b1, 2, 32'h0, "con_valid_after_midreset");
    drive(1'b0, UNMAP, 32'h0, 1'b1, 3, 32'h0, "con_data_after_midreset");
    drive(1'b0, 32'h10, 32'h0, 1'b0, 1, 32'hDEAD_BEEF, "ram_kept_through_reset");
    drive(1'b0, UNMAP,  32'h0, 1'b0, 1, 32'h0, "unmapped_read");
    drive(1'b0, MMIO_CYCLE, 32'h0, 1'b0, 1, CYC_EN ? 32'(cyc) : 32'd0, "cycle_after_n");

    n_cmp++;
    if (byte_q.size() != 0) begin
      n_bad++;
      $display("FAIL con_bytes_left: got %0d undelivered expected 0", byte_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
